// File: rtl/cpu_io_bridge.sv
// CPU memory-port bridge: a 16-byte I/O window holds the console TX FIFO, the RX byte
// latch, a prescaled timer and a status register; every other address goes to external RAM.
module cpu_io_bridge #(
  parameter logic [15:0] IO_BASE    = 16'hFFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMER_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [15:0]     PRESC_LAST = 16'(TIMER_DIV - 1);

  typedef enum logic [3:0] {
    REG_TX_DATA  = 4'd0,
    REG_STATUS   = 4'd1,
    REG_RX_DATA  = 4'd2,
    REG_TIMER_LO = 4'd3,
    REG_TIMER_HI = 4'd4,
    REG_TX_COUNT = 4'd5
  } reg_e;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   presc_q, presc_d;
  logic [7:0]    shadow_q, shadow_d;

  logic io_hit, tx_full, tx_empty, pop, push;
  logic wr_tx, wr_status, wr_timer, rd_rx, rd_timer_lo;
  reg_e reg_off;

  assign io_hit   = (cpu_addr[15:4] == IO_BASE[15:4]);
  assign reg_off  = reg_e'(cpu_addr[3:0]);
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_we & ~io_hit;

  assign wr_tx       = cpu_we & io_hit & (reg_off == REG_TX_DATA);
  assign wr_status   = cpu_we & io_hit & (reg_off == REG_STATUS);
  assign wr_timer    = cpu_we & io_hit & (reg_off == REG_TIMER_LO);
  assign rd_rx       = cpu_re & io_hit & (reg_off == REG_RX_DATA);
  assign rd_timer_lo = cpu_re & io_hit & (reg_off == REG_TIMER_LO);

  assign tx_full  = (count_q == FULL_CNT);
  assign tx_empty = (count_q == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = fifo_q[rd_ptr_q];
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push     = wr_tx & (~tx_full | pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cpu_rdata = ram_rdata;
    if (io_hit) begin
      case (reg_off)
        REG_STATUS:   cpu_rdata = {3'b000, rx_ovr_q, tx_ovf_q, rx_valid_q, tx_empty, tx_full};
        REG_RX_DATA:  cpu_rdata = rx_byte_q;
        REG_TIMER_LO: cpu_rdata = timer_q[7:0];
        REG_TIMER_HI: cpu_rdata = shadow_q;
        REG_TX_COUNT: cpu_rdata = 8'(count_q);
        default:      cpu_rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // Sticky flags: a set event in the same cycle as a W1C wins.
    tx_ovf_d = (wr_tx & tx_full & ~pop) | (tx_ovf_q & ~(wr_status & cpu_wdata[3]));
    rx_ovr_d = (rx_valid_in & rx_valid_q & ~rd_rx) | (rx_ovr_q & ~(wr_status & cpu_wdata[4]));

    rx_byte_d  = rx_valid_in ? rx_data_in : rx_byte_q;
    rx_valid_d = rx_valid_in | (rx_valid_q & ~rd_rx);

    shadow_d = rd_timer_lo ? timer_q[15:8] : shadow_q;
    timer_d  = timer_q;
    presc_d  = presc_q + 16'd1;
    if (wr_timer) begin
      timer_d = 16'h0000;
      presc_d = 16'h0000;
    end else if (presc_q == PRESC_LAST) begin
      timer_d = timer_q + 16'd1;
      presc_d = 16'h0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: FIFO storage is reset too, so tx_data reads 0 out of reset and nothing queued survives.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      timer_q    <= 16'h0000;
      presc_q    <= 16'h0000;
      shadow_q   <= 8'h00;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= cpu_wdata;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      shadow_q   <= shadow_d;
    end
  end

endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Memory-side bridge that sits directly downstream of the CPU core's memory port and serves every CPU read/write. Addresses in a 16-byte I/O window are decoded to on-chip registers (console TX FIFO, RX byte latch, free-running timer, status). All other addresses pass through to external RAM. Reads are combinational so the core can latch read data in the same cycle it asserts its read enable.

## Interface
Parameters:
- IO_BASE, 16'hFFF0, base of the I/O window; low 4 bits must be 0; window is IO_BASE..IO_BASE+15
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..64
- TIMER_DIV, 1, timer increments once every TIMER_DIV cycles; 1..65535

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe
- cpu_rdata  out  8  read data, combinational from cpu_addr/state
- ram_addr  out  16  = cpu_addr
- ram_wdata  out  8  = cpu_wdata
- ram_we  out  1  cpu_we and address outside I/O window
- ram_rdata  in  8  RAM read data, asynchronous
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  consumer accepts head when tx_valid & tx_ready
- rx_data_in  in  8  incoming byte
- rx_valid_in  in  1  one-cycle strobe: rx_data_in valid

## Operation
- io_hit = (cpu_addr[15:4] == IO_BASE[15:4]); reg = cpu_addr[3:0].
- cpu_rdata = ram_rdata when !io_hit, else register value below; independent of cpu_re.
- Register map (offset: read / write):
  - 0 TX_DATA: reads 0 / push cpu_wdata into FIFO; if full and no pop this cycle, byte dropped, tx_ovf set
  - 1 STATUS: {3'b0, rx_ovr, tx_ovf, rx_valid, tx_empty, tx_full} / W1C on bit3 (tx_ovf), bit4 (rx_ovr); other bits ignored
  - 2 RX_DATA: rx byte / ignored; a read (cpu_re) clears rx_valid
  - 3 TIMER_LO: timer[7:0]; a read copies timer[15:8] into timer_shadow / clears timer and prescaler
  - 4 TIMER_HI: timer_shadow / ignored
  - 5 TX_COUNT: FIFO occupancy zero-extended to 8 bits / ignored
  - 6..15: read 0 / ignored
- Read side effects apply on each clock edge where cpu_re=1 and the address matches.
- Writes inside the window never reach RAM.
- TX FIFO: circular buffer with read/write pointers and a count of log2(FIFO_DEPTH)+1 bits. Pop on tx_valid & tx_ready. Push and pop in the same cycle: both take effect, count unchanged; a push while full is accepted if a pop occurs that cycle.
- RX: rx_valid_in stores rx_data_in and sets rx_valid. If rx_valid is already set and RX_DATA is not read that cycle: new byte overwrites, rx_ovr set. If RX_DATA is read the same cycle: new byte stored, rx_valid stays 1, no overrun.
- Timer: 16-bit counter; prescaler counts 0..TIMER_DIV-1, and the timer increments when the prescaler wraps. Wraps 0xFFFF -> 0x0000. A clear write beats an increment in the same cycle.
- Sticky flags: W1C clear and a new set event in the same cycle leave the flag set.

## Timing
- Reset (async, immediate): FIFO pointers/count 0, FIFO storage 0, tx_valid 0, tx_data 0, rx byte 0, rx_valid 0, tx_ovf 0, rx_ovr 0, timer 0, prescaler 0, timer_shadow 0.
- Reset asserted mid-transfer discards FIFO contents; no partial state survives.
- cpu_rdata, ram_*: zero-cycle combinational.
- Pushed byte visible on tx_data/tx_valid the cycle after the write edge, if the FIFO was empty.
- Status bits reflect state as of the last edge.
- RX byte readable the cycle after the rx_valid_in edge.
- With TIMER_DIV=1, the timer reads N exactly N cycles after reset release.

## Test plan
- Reset then write 0x41, 0x42, 0x43 to 0xFFF0 with tx_ready=0 -> TX_COUNT=3, STATUS=0x00; raise tx_ready -> tx_data 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0, STATUS=0x02.
- FIFO_DEPTH=8, tx_ready=0, 9 pushes -> STATUS=0x09, 9th byte lost. Write 0x08 to 0xFFF1 -> STATUS=0x01. Push with tx_ready=1 while full -> accepted, count stays 8.
- rx_valid_in with 0x5A, then 0x5B without a read -> RX_DATA=0x5B, STATUS bit2=1, bit4=1. Read 0xFFF2 -> bit2 clears. Strobe rx_valid_in in the same cycle as the read -> rx_valid stays 1, bit4 unchanged.
- TIMER_DIV=1: preload via 0xFFFE cycles, read 0xFFF3 -> low byte; read 0xFFF4 after the high byte changes -> snapshot value. Let the timer run past 0xFFFF -> wraps to 0. Write 0xFFF3 -> next reads 0x00.
- Addresses 0x0000, 0xFFEF, 0xFFF0: writes raise ram_we only for the first two. Reads return ram_rdata for the first two and register data for 0xFFF0.
- Assert rst asynchronously mid-stream with 5 bytes queued -> tx_valid drops without a clock edge; all registers read their reset values.
